gmii_rx_frame_align: RTL and testbench

- Receive-side framing stage fed by the source-synchronous SDR input capture. Runs on its recovered clock.
- Takes registered GMII (8-bit) or MII (4-bit nibble) receive signals, finds preamble/SFD, and strips them.
- Emits the payload as a byte-wide AXI-stream with tlast/tuser. The MAC RX path consumes that stream; there is no backpressure.

---
 rtl/gmii_rx_frame_align_pkg.sv | 20 ++
 rtl/gmii_rx_nibble_pack.sv | 63 ++++++
 rtl/gmii_rx_frame_align.sv | 232 +++++++++++++++++++++++
 tb/tb_gmii_rx_frame_align.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_rx_frame_align_pkg.sv
// rtl/gmii_rx_frame_align_pkg.sv - shared constants and state type for the GMII/MII receive aligner
//
// Purpose : preamble/SFD symbol constants and the framing FSM state encoding.
// Ports   : none (package).

package gmii_rx_frame_align_pkg;

  localparam logic [7:0] ETH_PRE = 8'h55;
  localparam logic [7:0] ETH_SFD = 8'hD5;
  localparam logic [3:0] NIB_PRE = 4'h5;
  localparam logic [3:0] NIB_SFD = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;

endpackage

// File: rtl/gmii_rx_nibble_pack.sv
// rtl/gmii_rx_nibble_pack.sv - packs MII nibbles into bytes, passes GMII bytes through
//
// Purpose : byte assembly for the payload phase. MII takes the low nibble first.
// Ports   : clk, rst_n    - clock, asynchronous active-low reset
//           clear_i       - force nibble phase back to low (held outside payload)
//           en_i          - a valid payload sample is present on data_i
//           mii_i         - 1 = nibble mode, 0 = byte mode
//           data_i[7:0]   - registered receive data
//           byte_o[7:0]   - assembled byte, valid with byte_vld_o
//           byte_vld_o    - a byte completes this cycle
//           odd_o         - a lone low nibble is waiting for its partner

module gmii_rx_nibble_pack
  import gmii_rx_frame_align_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic       mii_i,
  input  logic [7:0] data_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       odd_o
);

  logic       phase_q, phase_d;
  logic [3:0] low_q, low_d;

  always_comb begin
    phase_d    = phase_q;
    low_d      = low_q;
    byte_o     = data_i;
    byte_vld_o = 1'b0;
    if (clear_i) begin
      phase_d = 1'b0;
    end else if (en_i) begin
      if (!mii_i) begin
        byte_vld_o = 1'b1;
      end else if (!phase_q) begin
        low_d   = data_i[3:0];
        phase_d = 1'b1;
      end else begin
        byte_o     = {data_i[3:0], low_q};
        byte_vld_o = 1'b1;
        phase_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      low_q   <= 4'h0;
    end else begin
      phase_q <= phase_d;
      low_q   <= low_d;
    end
  end

  assign odd_o = phase_q;

endmodule

// File: rtl/gmii_rx_frame_align.sv
// rtl/gmii_rx_frame_align.sv - GMII/MII receive preamble/SFD stripper with byte-wide stream output
//
// Purpose : registers the receive pins, locks onto preamble + SFD, and forwards the
//           payload through a one-byte hold register so the final byte can carry tlast.
// Ports   : clk, rst_n              - recovered receive clock, asynchronous active-low reset
//           mii_select             - 1 = MII nibbles, 0 = GMII bytes (taken at frame start)
//           gmii_rxd/rx_dv/rx_er   - receive pins from the capture stage
//           m_axis_tdata/tvalid/
//           tlast/tuser            - payload stream; tuser flags a bad frame on tlast
//           error_bad_frame        - pulse: frame ended without a forwarded beat
//           error_preamble         - pulse: bad preamble symbol or missing SFD

module gmii_rx_frame_align
  import gmii_rx_frame_align_pkg::*;
#(
  parameter int PREAMBLE_MAX = 7,
  parameter int MIN_PAYLOAD  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mii_select,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       error_bad_frame,
  output logic       error_preamble
);

  localparam logic [7:0] PRE_LIM_GMII = 8'(PREAMBLE_MAX);
  localparam logic [7:0] PRE_LIM_MII  = 8'(2 * PREAMBLE_MAX);
  localparam logic [7:0] MIN_BYTES    = 8'(MIN_PAYLOAD);

  rx_state_e  state_q, state_d;

  // input register stage
  logic       in_vld_q;
  logic       in_dv_q, in_er_q;
  logic [7:0] in_rxd_q;

  logic       armed_q, armed_d;
  logic       mode_q, mode_d;
  logic [7:0] pre_cnt_q, pre_cnt_d;
  logic       err_q, err_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] held_cnt_q, held_cnt_d;

  logic [7:0] tdata_q, tdata_d;
  logic       tvalid_q, tvalid_d;
  logic       tlast_q, tlast_d;
  logic       tuser_q, tuser_d;
  logic       bad_q, bad_d;
  logic       epre_q, epre_d;

  logic       mode_eff;
  logic [7:0] cnt_eff, pre_lim;
  logic       pre_cont, pre_sfd, pre_eval;

  logic       pack_clear, pack_en, pack_vld, pack_odd;
  logic [7:0] pack_byte;

  gmii_rx_nibble_pack u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (pack_clear),
    .en_i       (pack_en),
    .mii_i      (mode_q),
    .data_i     (in_rxd_q),
    .byte_o     (pack_byte),
    .byte_vld_o (pack_vld),
    .odd_o      (pack_odd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vld_q <= 1'b0;
      in_dv_q  <= 1'b0;
      in_er_q  <= 1'b0;
      in_rxd_q <= 8'h00;
    end else begin
      in_vld_q <= 1'b1;
      in_dv_q  <= gmii_rx_dv;
      in_er_q  <= gmii_rx_er;
      in_rxd_q <= gmii_rxd;
    end
  end

  // Preamble symbol classification. In IDLE the first sample is judged with the
  // live mode select and an empty count, so a frame can start without a wasted cycle.
  always_comb begin
    mode_eff = (state_q == ST_IDLE) ? mii_select : mode_q;
    cnt_eff  = (state_q == ST_IDLE) ? 8'd0 : pre_cnt_q;
    pre_lim  = mode_eff ? PRE_LIM_MII : PRE_LIM_GMII;
    pre_cont = 1'b0;
    pre_sfd  = 1'b0;
    if (!in_er_q) begin
      if (mode_eff) begin
        pre_cont = (in_rxd_q[3:0] == NIB_PRE) && (cnt_eff < pre_lim);
        // any non-5 nibble drops the frame, so a non-zero count means 0x5 came just before
        pre_sfd  = (in_rxd_q[3:0] == NIB_SFD) && (cnt_eff != 8'd0);
      end else begin
        pre_cont = (in_rxd_q == ETH_PRE) && (cnt_eff < pre_lim);
        pre_sfd  = (in_rxd_q == ETH_SFD);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    // only a dv=0 actually captured after reset may arm the FSM; the cleared input
    // register must not make a mid-frame release look like an idle line
    armed_d    = armed_q | (in_vld_q & ~in_dv_q);
    mode_d     = mode_q;
    pre_cnt_d  = pre_cnt_q;
    err_d      = err_q;
    hold_d     = hold_q;
    held_cnt_d = held_cnt_q;
    tdata_d    = tdata_q;
    tvalid_d   = 1'b0;
    tlast_d    = 1'b0;
    tuser_d    = 1'b0;
    bad_d      = 1'b0;
    epre_d     = 1'b0;
    pack_clear = (state_q != ST_PAYLOAD);
    pack_en    = 1'b0;
    pre_eval   = in_dv_q && (((state_q == ST_IDLE) && armed_q) || (state_q == ST_PREAMBLE));

    case (state_q)
      ST_IDLE: begin
        if (in_dv_q) begin
          if (!armed_q) begin
            state_d = ST_DROP;
          end else begin
            mode_d = mii_select;
            err_d  = 1'b0;
          end
        end
      end
      ST_PREAMBLE: begin
        if (!in_dv_q) begin
          state_d = ST_IDLE;
          epre_d  = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (in_dv_q) begin
          pack_en = 1'b1;
          if (in_er_q) err_d = 1'b1;
          if (pack_vld) begin
            if (held_cnt_q != 8'd0) begin
              tvalid_d = 1'b1;
              tdata_d  = hold_q;
            end
            hold_d     = pack_byte;
            held_cnt_d = (held_cnt_q == 8'hFF) ? held_cnt_q : held_cnt_q + 8'd1;
          end
        end else begin
          if ((held_cnt_q != 8'd0) && (held_cnt_q >= MIN_BYTES)) begin
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            tdata_d  = hold_q;
            tuser_d  = err_q | pack_odd;
          end else begin
            bad_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!in_dv_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (pre_eval) begin
      if (pre_cont) begin
        state_d   = ST_PREAMBLE;
        pre_cnt_d = cnt_eff + 8'd1;
      end else if (pre_sfd) begin
        state_d    = ST_PAYLOAD;
        held_cnt_d = 8'd0;
        err_d      = 1'b0;
      end else begin
        state_d = ST_DROP;
        epre_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      armed_q    <= 1'b0;
      mode_q     <= 1'b0;
      pre_cnt_q  <= 8'd0;
      err_q      <= 1'b0;
      hold_q     <= 8'h00;
      held_cnt_q <= 8'd0;
      tdata_q    <= 8'h00;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      bad_q      <= 1'b0;
      epre_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      mode_q     <= mode_d;
      pre_cnt_q  <= pre_cnt_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
      held_cnt_q <= held_cnt_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      bad_q      <= bad_d;
      epre_q     <= epre_d;
    end
  end

  assign m_axis_tdata    = tdata_q;
  assign m_axis_tvalid   = tvalid_q;
  assign m_axis_tlast    = tlast_q;
  assign m_axis_tuser    = tuser_q;
  assign error_bad_frame = bad_q;
  assign error_preamble  = epre_q;

endmodule

// File: tb/tb_gmii_rx_frame_align.sv
// tb/tb_gmii_rx_frame_align.sv - scoreboard bench for gmii_rx_frame_align

module tb_gmii_rx_frame_align;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mii_select = 1'b0;
  logic [7:0] gmii_rxd = 8'h00;
  logic       gmii_rx_dv = 1'b0;
  logic       gmii_rx_er = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic       error_bad_frame, error_preamble;

  gmii_rx_frame_align #(.PREAMBLE_MAX(7), .MIN_PAYLOAD(1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mii_select      (mii_select),
    .gmii_rxd        (gmii_rxd),
    .gmii_rx_dv      (gmii_rx_dv),
    .gmii_rx_er      (gmii_rx_er),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tuser    (m_axis_tuser),
    .error_bad_frame (error_bad_frame),
    .error_preamble  (error_preamble)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_pre    = 0;
  int n_bad    = 0;
  int first_cyc = 0;
  int lat_mark  = 0;
  bit mon_first = 1'b1;

  logic [9:0] exp_q[$];   // {tlast, tuser, tdata}
  logic [7:0] sq[$];
  logic       eq[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) mon_first = 1'b1;
    if (error_preamble) n_pre++;
    if (error_bad_frame) n_bad++;
    if (m_axis_tvalid) begin
      if (mon_first) first_cyc = cyc;
      mon_first = m_axis_tlast;
      check_eq("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        check_eq("beat", {22'd0, m_axis_tlast, m_axis_tuser, m_axis_tdata}, {22'd0, exp_q.pop_front()});
      if (m_axis_tlast)
        check_eq("err_on_last", {30'd0, error_bad_frame, error_preamble}, 32'd0);
    end
  end

  task automatic put(input logic [7:0] b, input logic e);
    sq.push_back(b);
    eq.push_back(e);
  endtask

  task automatic pre_gmii(input int n);
    for (int i = 0; i < n; i++) put(8'h55, 1'b0);
  endtask

  task automatic pre_mii(input int n);
    for (int i = 0; i < n; i++) put(8'hA5, 1'b0);
    put(8'hAD, 1'b0);
  endtask

  task automatic mii_byte(input logic [7:0] b);
    put({4'hA, b[3:0]}, 1'b0);
    put({4'hA, b[7:4]}, 1'b0);
  endtask

  task automatic expect_beat(input logic [7:0] b, input logic last, input logic user);
    exp_q.push_back({last, user, b});
  endtask

  // mark: symbol index whose drive cycle is recorded; flip: symbol index at which mii_select toggles
  task automatic drive_syms(input int mark, input int flip);
    int i;
    i = 0;
    while (sq.size() != 0) begin
      gmii_rxd   = sq.pop_front();
      gmii_rx_er = eq.pop_front();
      gmii_rx_dv = 1'b1;
      if (i == mark) lat_mark = cyc;
      if (i == flip) mii_select = ~mii_select;
      i++;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    gmii_rxd   = 8'h00;
    repeat (n) @(negedge clk);
  endtask

  task automatic tally(input string tag, input int pre0, input int bad0, input int epre, input int ebad);
    check_eq({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_epre"}, 32'(n_pre - pre0), 32'(epre));
    check_eq({tag, "_ebad"}, 32'(n_bad - bad0), 32'(ebad));
  endtask

  function automatic logic [31:0] outs();
    return {19'd0, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser, error_bad_frame, error_preamble};
  endfunction

  initial begin
    int pre0, bad0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", outs(), 32'd0);
    rst_n = 1'b1;
    idle(3);

    // GMII 64-byte frame, latency of first beat
    pre0 = n_pre; bad0 = n_bad;
    pre_gmii(7); put(8'hD5, 1'b0);
    for (int i = 1; i <= 64; i++) begin
      put(8'(i), 1'b0);
      expect_beat(8'(i), i == 64, 1'b0);
    end
    drive_syms(8, -1);
    idle(6);
    check_eq("gmii_first_lat", 32'(first_cyc - lat_mark), 32'd3);
    tally("gmii64", pre0, bad0, 0, 0);

    // MII frame, one-cycle gap, then MII frame with odd trailing nibble and mode flip
    pre0 = n_pre; bad0 = n_bad;
    mii_select = 1'b1;
    pre_mii(14);
    mii_byte(8'hA1); mii_byte(8'hB2); mii_byte(8'hC3);
    expect_beat(8'hA1, 1'b0, 1'b0);
    expect_beat(8'hB2, 1'b0, 1'b0);
    expect_beat(8'hC3, 1'b1, 1'b0);
    drive_syms(-1, -1);
    idle(1);
    pre_mii(14);
    mii_byte(8'h11); mii_byte(8'h22); put(8'hA3, 1'b0);
    expect_beat(8'h11, 1'b0, 1'b0);
    expect_beat(8'h22, 1'b1, 1'b1);
    drive_syms(-1, 15);
    idle(6);
    tally("mii", pre0, bad0, 0, 0);
    mii_select = 1'b0;

    // GMII er on payload byte 10 of 20
    pre0 = n_pre; bad0 = n_bad;
    pre_gmii(7); put(8'hD5, 1'b0);
    for (int i = 0; i < 20; i++) begin
      put(8'h80 + 8'(i), i == 9);
      expect_beat(8'h80 + 8'(i), i == 19, i == 19);
    end
    drive_syms(-1, -1);
    idle(6);
    tally("gmii_er", pre0, bad0, 0, 0);

    // bad preamble symbol, rest of frame ignored, next frame decodes
    pre0 = n_pre; bad0 = n_bad;
    put(8'h55, 1'b0); put(8'h55, 1'b0); put(8'h12, 1'b0);
    put(8'h55, 1'b0); put(8'hD5, 1'b0); put(8'h33, 1'b0); put(8'h44, 1'b0);
    drive_syms(-1, -1);
    idle(4);
    pre_gmii(7); put(8'hD5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      put(8'hF0 + 8'(i), 1'b0);
      expect_beat(8'hF0 + 8'(i), i == 2, 1'b0);
    end
    drive_syms(-1, -1);
    idle(6);
    tally("pre_bad", pre0, bad0, 1, 0);

    // dv drops right after SFD
    pre0 = n_pre; bad0 = n_bad;
    pre_gmii(7); put(8'hD5, 1'b0);
    drive_syms(-1, -1);
    idle(6);
    tally("no_pay", pre0, bad0, 0, 1);

    // preamble longer than PREAMBLE_MAX
    pre0 = n_pre; bad0 = n_bad;
    pre_gmii(9); put(8'hD5, 1'b0); put(8'h01, 1'b0); put(8'h02, 1'b0);
    drive_syms(-1, -1);
    idle(6);
    tally("long_pre", pre0, bad0, 1, 0);

    // reset mid-payload, release with dv high, then a normal frame
    pre0 = n_pre; bad0 = n_bad;
    pre_gmii(7); put(8'hD5, 1'b0);
    for (int i = 0; i < 10; i++) begin
      put(8'h40 + 8'(i), 1'b0);
      if (i < 8) expect_beat(8'h40 + 8'(i), 1'b0, 1'b0);
    end
    drive_syms(-1, -1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_outputs", outs(), 32'd0);
    for (int i = 0; i < 3; i++) put(8'h77, 1'b0);
    drive_syms(-1, -1);
    rst_n = 1'b1;
    pre_gmii(7); put(8'hD5, 1'b0); put(8'h99, 1'b0); put(8'h98, 1'b0);
    drive_syms(-1, -1);
    idle(4);
    pre_gmii(7); put(8'hD5, 1'b0);
    put(8'h5A, 1'b0); put(8'h5B, 1'b0);
    expect_beat(8'h5A, 1'b0, 1'b0);
    expect_beat(8'h5B, 1'b1, 1'b0);
    drive_syms(-1, -1);
    idle(6);
    tally("rst", pre0, bad0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
